// File: rtl/ice40up_mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single-port synchronous memory.
// Each access takes three cycles: IDLE (arbitrate and latch the winner), ISSUE (mem_en high,
// writes commit at the closing edge) and RESP (owner's ack pulses with mem_rdata).
// Ties use round-robin on a last-grant pointer; define MEM_ARB_FIXED_PRIORITY_EN to make
// the data port always win ties instead.
module ice40up_mem_arbiter (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_ack,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wr_mask,
  output logic        mem_en,
  output logic        mem_wr_en,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        w_any_req;
  logic        w_grant_data;
  logic        w_start;
  logic        r_owner_data;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wr_mask;
  logic        r_mem_wr_en;
  logic [31:0] r_instr_data;
  logic [31:0] r_data_rd_data;

  assign w_any_req = instr_req | data_req;
  assign w_start   = (r_state == StIdle) & w_any_req;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  // Data port always wins; no pointer is kept.
  assign w_grant_data = data_req;
`else
  // High means the data port got the most recent grant; reset favours data on the first tie.
  logic r_last_data;

  assign w_grant_data = data_req & (~instr_req | ~r_last_data);

  // Last-grant pointer, updated on every grant
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_last_data <= 1'b0;
    end else if (w_start) begin
      r_last_data <= w_grant_data;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the per-state strobes (mem_en, acks)
  always_comb begin
    w_state_next = r_state;
    mem_en       = 1'b0;
    instr_ack    = 1'b0;
    data_ack     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any_req) w_state_next = StIssue;
      end
      StIssue: begin
        mem_en       = 1'b1;
        w_state_next = StResp;
      end
      StResp: begin
        instr_ack    = ~r_owner_data;
        data_ack     = r_owner_data;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Latch the winner's access fields; they stay put through ISSUE and RESP
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_owner_data  <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_mem_wdata   <= 32'h0;
      r_mem_wr_mask <= 4'h0;
      r_mem_wr_en   <= 1'b0;
    end else if (w_start) begin
      r_owner_data <= w_grant_data;
      if (w_grant_data) begin
        r_mem_addr    <= data_addr;
        r_mem_wdata   <= data_wr_data;
        r_mem_wr_mask <= data_mask;
        r_mem_wr_en   <= data_wr_en;
      end else begin
        // Instruction fetches never write
        r_mem_addr    <= instr_addr;
        r_mem_wdata   <= 32'h0;
        r_mem_wr_mask <= 4'h0;
        r_mem_wr_en   <= 1'b0;
      end
    end
  end

  // Keep the last acked read data so the outputs hold between acks
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_instr_data   <= 32'h0;
      r_data_rd_data <= 32'h0;
    end else begin
      if (instr_ack) r_instr_data <= mem_rdata;
      if (data_ack)  r_data_rd_data <= mem_rdata;
    end
  end

  // During the ack cycle the memory word passes straight through
  assign instr_data   = instr_ack ? mem_rdata : r_instr_data;
  assign data_rd_data = data_ack ? mem_rdata : r_data_rd_data;

  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wr_mask = r_mem_wr_mask;
  assign mem_wr_en   = r_mem_wr_en;

endmodule

// File: tb/tb_ice40up_mem_arbiter.sv
// Bench for ice40up_mem_arbiter: directed scenarios followed by randomized traffic checked
// against a transaction-level model (grant times, round-robin winner, shadow memory).
// Build with MEM_ARB_FIXED_PRIORITY_EN to expect data-first tie breaking.
module tb_ice40up_mem_arbiter;

  logic        clk;
  logic        rstz;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_ack;
  logic [31:0] data_rd_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wr_mask;
  logic        mem_en;
  logic        mem_wr_en;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_fail;

  logic [31:0] sim_mem [16];
  logic [31:0] ref_mem [16];
  logic        mem_load;

  ice40up_mem_arbiter dut (
    .clk          (clk),
    .rstz         (rstz),
    .instr_addr   (instr_addr),
    .instr_req    (instr_req),
    .instr_ack    (instr_ack),
    .instr_data   (instr_data),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_mask    (data_mask),
    .data_wr_en   (data_wr_en),
    .data_req     (data_req),
    .data_ack     (data_ack),
    .data_rd_data (data_rd_data),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wr_mask  (mem_wr_mask),
    .mem_en       (mem_en),
    .mem_wr_en    (mem_wr_en),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5C3_0000 ^ (i * 32'h0101_1357);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Synchronous memory: read data one cycle after mem_en, read-before-write on writes
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) sim_mem[i] <= init_word(i);
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      mem_rdata <= sim_mem[mem_addr[5:2]];
      if (mem_wr_en) sim_mem[mem_addr[5:2]] <= merge(sim_mem[mem_addr[5:2]], mem_wdata,
                                                     mem_wr_mask);
    end
  end

  task automatic do_reset();
    rstz      = 1'b0;
    instr_req = 1'b0;
    data_req  = 1'b0;
    repeat (2) @(negedge clk);
    rstz = 1'b1;
  endtask

  task automatic test_reset();
    mem_load     = 1'b1;
    rstz         = 1'b0;
    instr_req    = 1'b0;
    instr_addr   = 32'h0;
    data_req     = 1'b0;
    data_addr    = 32'h0;
    data_wr_data = 32'h0;
    data_mask    = 4'h0;
    data_wr_en   = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_en, mem_wr_en, instr_ack, data_ack} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes got=%b exp=0000", {mem_en, mem_wr_en, instr_ack, data_ack});
    end
    n_checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wr_mask !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mem_fields got=%h/%h/%h exp=0/0/0", mem_addr, mem_wdata, mem_wr_mask);
    end
    n_checks++;
    if (instr_data !== 32'h0 || data_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata got=%h/%h exp=0/0", instr_data, data_rd_data);
    end
    mem_load = 1'b0;
    rstz     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    instr_req  = 1'b1;
    instr_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_wr_en !== 1'b0 || mem_wr_mask !== 4'h0)
    begin
      n_fail++;
      $display("FAIL read_issue got en=%b addr=%h we=%b mask=%h exp en=1 addr=100 we=0 mask=0",
               mem_en, mem_addr, mem_wr_en, mem_wr_mask);
    end
    @(negedge clk);
    n_checks++;
    if (instr_ack !== 1'b1 || data_ack !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL read_ack got iack=%b dack=%b en=%b exp 1 0 0", instr_ack, data_ack, mem_en);
    end
    n_checks++;
    if (instr_data !== ref_mem[0]) begin
      n_fail++;
      $display("FAIL read_data got=%h exp=%h", instr_data, ref_mem[0]);
    end
    instr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (instr_ack !== 1'b0 || instr_data !== ref_mem[0]) begin
      n_fail++;
      $display("FAIL read_hold got ack=%b data=%h exp ack=0 data=%h", instr_ack, instr_data,
               ref_mem[0]);
    end
  endtask

  task automatic test_masked_write();
    logic [31:0] old_w;
    old_w        = ref_mem[1];
    data_req     = 1'b1;
    data_wr_en   = 1'b1;
    data_addr    = 32'h8004;
    data_wr_data = 32'hDEADBEEF;
    data_mask    = 4'b0011;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || mem_wr_en !== 1'b1 || mem_wr_mask !== 4'b0011 ||
        mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h8004) begin
      n_fail++;
      $display("FAIL write_issue got en=%b we=%b mask=%b wd=%h addr=%h exp 1 1 0011 deadbeef 8004",
               mem_en, mem_wr_en, mem_wr_mask, mem_wdata, mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (data_ack !== 1'b1 || instr_ack !== 1'b0 || data_rd_data !== old_w) begin
      n_fail++;
      $display("FAIL write_ack got dack=%b iack=%b rd=%h exp 1 0 %h", data_ack, instr_ack,
               data_rd_data, old_w);
    end
    data_req   = 1'b0;
    data_wr_en = 1'b0;
    ref_mem[1] = merge(old_w, 32'hDEADBEEF, 4'b0011);
    @(negedge clk);
    // Read the word back to confirm only the masked bytes changed
    instr_req  = 1'b1;
    instr_addr = 32'h8004;
    repeat (2) @(negedge clk);
    n_checks++;
    if (instr_ack !== 1'b1 || instr_data !== ref_mem[1]) begin
      n_fail++;
      $display("FAIL write_readback got ack=%b data=%h exp ack=1 data=%h", instr_ack, instr_data,
               ref_mem[1]);
    end
    instr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    logic exp_data;
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'h0;
    data_req   = 1'b1;
    data_addr  = 32'h4;
    data_wr_en = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      exp_data = 1'b1;
`else
      exp_data = ((j / 3) % 2) == 0;
`endif
      n_checks++;
      if ((j % 3) == 2) begin
        if (data_ack !== exp_data || instr_ack !== !exp_data) begin
          n_fail++;
          $display("FAIL tie_grant%0d got dack=%b iack=%b exp dack=%b iack=%b", j / 3, data_ack,
                   instr_ack, exp_data, !exp_data);
        end
      end else if (data_ack !== 1'b0 || instr_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL tie_quiet_c%0d got dack=%b iack=%b exp 0 0", j, data_ack, instr_ack);
      end
    end
    instr_req = 1'b0;
    data_req  = 1'b0;
  endtask

  task automatic test_reset_during_issue();
    instr_req  = 1'b1;
    instr_addr = 32'h24;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_issue_before got en=%b exp 1", mem_en);
    end
    rstz = 1'b0;
    #1;
    n_checks++;
    if (mem_en !== 1'b0 || instr_ack !== 1'b0 || data_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_issue_abort got en=%b iack=%b dack=%b exp 0 0 0", mem_en, instr_ack,
               data_ack);
    end
    @(negedge clk);
    n_checks++;
    if (instr_ack !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_issue_held got iack=%b en=%b exp 0 0", instr_ack, mem_en);
    end
    rstz = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h24 || instr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_reissue got en=%b addr=%h iack=%b exp 1 24 0", mem_en, mem_addr,
               instr_ack);
    end
    @(negedge clk);
    n_checks++;
    if (instr_ack !== 1'b1 || instr_data !== ref_mem[9]) begin
      n_fail++;
      $display("FAIL rst_complete got ack=%b data=%h exp ack=1 data=%h", instr_ack, instr_data,
               ref_mem[9]);
    end
    instr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_withdrawn();
    int acks;
    int issues;
    instr_req  = 1'b1;
    instr_addr = 32'h3C;
    @(negedge clk);
    instr_req = 1'b0;
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h3C) begin
      n_fail++;
      $display("FAIL withdrawn_issue got en=%b addr=%h exp 1 3c", mem_en, mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (instr_ack !== 1'b1 || instr_data !== ref_mem[15]) begin
      n_fail++;
      $display("FAIL withdrawn_ack got ack=%b data=%h exp ack=1 data=%h", instr_ack, instr_data,
               ref_mem[15]);
    end
    acks   = 0;
    issues = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      acks   += int'(instr_ack) + int'(data_ack);
      issues += int'(mem_en);
    end
    n_checks++;
    if (acks != 0 || issues != 0) begin
      n_fail++;
      $display("FAIL withdrawn_no_repeat got acks=%0d issues=%0d exp 0 0", acks, issues);
    end
  endtask

  // Randomized traffic. Both ports follow the hold-until-ack protocol; the model grants at
  // the first free IDLE slot, three cycles per access, and tracks expected memory contents.
  task automatic test_random();
    bit          i_act, d_act, last_data, exp_valid, exp_dport, win_data, e_iack, e_dack;
    int          next_free, exp_issue, exp_ack;
    logic [31:0] exp_addr, exp_wdata, exp_rdata, hold_i, hold_d;
    logic [3:0]  exp_mask, idx;
    logic        exp_wr;
    do_reset();
    i_act = 0; d_act = 0; last_data = 0; exp_valid = 0; exp_dport = 0;
    next_free = 0; exp_issue = -1; exp_ack = -1;
    exp_addr = 0; exp_wdata = 0; exp_rdata = 0; exp_mask = 0; exp_wr = 0;
    hold_i = 0; hold_d = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++;
      if (mem_en !== (exp_valid && c == exp_issue)) begin
        n_fail++;
        $display("FAIL rnd_mem_en c=%0d got=%b exp=%b", c, mem_en, exp_valid && c == exp_issue);
      end
      if (exp_valid && c == exp_issue) begin
        n_checks++;
        if (mem_addr !== exp_addr || mem_wr_en !== exp_wr || mem_wr_mask !== exp_mask ||
            (exp_wr && mem_wdata !== exp_wdata)) begin
          n_fail++;
          $display("FAIL rnd_issue c=%0d got addr=%h we=%b mask=%h wd=%h exp %h %b %h %h", c,
                   mem_addr, mem_wr_en, mem_wr_mask, mem_wdata, exp_addr, exp_wr, exp_mask,
                   exp_wdata);
        end
      end
      e_iack = exp_valid && c == exp_ack && !exp_dport;
      e_dack = exp_valid && c == exp_ack && exp_dport;
      if (e_iack) hold_i = exp_rdata;
      if (e_dack) hold_d = exp_rdata;
      n_checks++;
      if (instr_ack !== e_iack || data_ack !== e_dack) begin
        n_fail++;
        $display("FAIL rnd_ack c=%0d got iack=%b dack=%b exp %b %b", c, instr_ack, data_ack,
                 e_iack, e_dack);
      end
      n_checks++;
      if (instr_data !== hold_i || data_rd_data !== hold_d) begin
        n_fail++;
        $display("FAIL rnd_rdata c=%0d got i=%h d=%h exp %h %h", c, instr_data, data_rd_data,
                 hold_i, hold_d);
      end
      if (e_iack || e_dack) exp_valid = 0;
      // Drive the next inputs
      if (e_iack) i_act = 0;
      if (e_dack) d_act = 0;
      if (!i_act && $urandom_range(0, 99) < 45) begin
        i_act      = 1;
        instr_addr = $urandom;
      end
      if (!d_act && $urandom_range(0, 99) < 45) begin
        d_act        = 1;
        data_addr    = $urandom;
        data_wr_data = $urandom;
        data_mask    = 4'($urandom_range(0, 15));
        data_wr_en   = 1'($urandom_range(0, 1));
      end
      instr_req = i_act;
      data_req  = d_act;
      // Model: a request visible at a free slot is granted at the coming edge
      if (c >= next_free && (i_act || d_act)) begin
        if (i_act && d_act) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
          win_data = 1;
`else
          win_data = !last_data;
`endif
        end else begin
          win_data = d_act;
        end
        last_data = win_data;
        exp_valid = 1;
        exp_dport = win_data;
        exp_issue = c + 1;
        exp_ack   = c + 2;
        next_free = c + 3;
        exp_addr  = win_data ? data_addr : instr_addr;
        exp_wr    = win_data ? data_wr_en : 1'b0;
        exp_mask  = win_data ? data_mask : 4'h0;
        exp_wdata = data_wr_data;
        idx       = exp_addr[5:2];
        exp_rdata = ref_mem[idx];
        if (exp_wr) ref_mem[idx] = merge(ref_mem[idx], exp_wdata, exp_mask);
      end
    end
    instr_req = 1'b0;
    data_req  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_read();
    test_masked_write();
    test_tie();
    test_reset_during_issue();
    test_withdrawn();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ice40up_mem_arbiter.md
ICE40UP_MEM_ARBITER -- requirements
Module: ice40up_mem_arbiter

Interface
- REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
- REQ-002 clk  input  1  system clock; all logic on rising edge.
- REQ-003 rstz  input  1  asynchronous, active-low reset.
- REQ-004 instr_addr  input  32  instruction-port byte address.
- REQ-005 instr_req  input  1  instruction read request, held until instr_ack.
- REQ-006 instr_ack  output  1  instruction access-complete pulse.
- REQ-007 instr_data  output  32  instruction read data, valid with instr_ack.
- REQ-008 data_addr  input  32  data-port byte address.
- REQ-009 data_wr_data  input  32  data-port write data.
- REQ-010 data_mask  input  4  data-port byte write mask.
- REQ-011 data_wr_en  input  1  data-port access is a write.
- REQ-012 data_req  input  1  data-port request, held until data_ack.
- REQ-013 data_ack  output  1  data access-complete pulse.
- REQ-014 data_rd_data  output  32  data read data, valid with data_ack.
- REQ-015 mem_addr, mem_wdata  output  32 each  memory address and write data.
- REQ-016 mem_wr_mask  output  4  memory byte write mask.
- REQ-017 mem_en, mem_wr_en  output  1 each  memory enable and write enable.
- REQ-018 mem_rdata  input  32  memory read data, valid one cycle after the mem_en cycle.

Function
- REQ-019 FSM states SHALL be IDLE, ISSUE and RESP; transitions are IDLE->ISSUE on any request, ISSUE->RESP and RESP->IDLE unconditionally.
- REQ-020 In IDLE with at least one request, the arbiter SHALL pick a winner and register mem_addr, mem_wdata, mem_wr_mask and mem_wr_en from the winning port, plus an owner bit.
- REQ-021 The instruction port SHALL drive mem_wr_en=0 and mem_wr_mask=4'b0000.
- REQ-022 mem_en SHALL be 1 in ISSUE only; memory-port fields SHALL hold stable from ISSUE through RESP.
- REQ-023 In RESP, exactly one of instr_ack or data_ack (the owner's) SHALL be 1 for one cycle, and the owner's read-data output SHALL equal mem_rdata.
- REQ-024 Acks SHALL also be issued for writes; the write is committed at the ISSUE clock edge.
- REQ-025 Latency SHALL be exactly 3 cycles from request seen in IDLE to ack; peak throughput is one access per 3 cycles.
- REQ-026 If both requests are present in IDLE, round-robin SHALL apply: the port not granted last wins, and the last-grant pointer updates on every grant.
- REQ-027 Read-data outputs SHALL hold their last acked value when not acking.
- REQ-028 A request withdrawn before its ack (protocol violation) SHALL still complete; the ack SHALL still pulse.
- REQ-029 A request still high in the cycle after its ack SHALL be treated as a new request.

Reset
- REQ-030 While rstz=0: state=IDLE; mem_en, mem_wr_en, both acks=0; mem_addr, mem_wdata, mem_wr_mask, instr_data, data_rd_data=0; last-grant pointer=instruction, so data wins the first tie.
- REQ-031 Reset asserted mid-access SHALL abort the access with no ack; after release, the arbiter SHALL re-arbitrate from IDLE.

Configuration
- REQ-032 With MEM_ARB_FIXED_PRIORITY_EN defined, the data port SHALL always win ties and the pointer is unused; without it, REQ-026 round-robin applies.

Verification
- REQ-033 Single read: instr_req=1, instr_addr=0x100 -> mem_en=1 and mem_addr=0x100 in cycle 2; instr_ack=1 in cycle 3 with instr_data=mem_rdata; data_ack stays 0.
- REQ-034 Masked write: data_req=1, data_wr_en=1, data_addr=0x8004, data_wr_data=0xDEADBEEF, data_mask=4'b0011 -> ISSUE shows mem_wr_en=1, mem_wr_mask=4'b0011, mem_wdata=0xDEADBEEF; data_ack in RESP.
- REQ-035 Tie after reset: both requests held continuously -> grant order data, instr, data, instr; acks 3 cycles apart; with MEM_ARB_FIXED_PRIORITY_EN, data only.
- REQ-036 Reset during ISSUE: rstz=0 -> mem_en=0 immediately, no ack; after release, the pending request completes 3 cycles after IDLE.
- REQ-037 Withdrawn request: instr_req pulsed for 1 cycle -> access completes and instr_ack pulses once; no second access follows.
